// File: rtl/pc_jump_sequencer_if.sv
// Jump request channel between the jump-decision logic (master) and the
// program counter sequencer (slave).
// Optional macro PC_RETURN_STACK_EN adds the call/return qualifiers.
//
// Handshake: the master raises jump_req with a stable jump_target (and
// call/ret qualifiers) and holds them until it samples jump_ack=1 on a
// clock edge; jump_ack is combinational and is high only in the cycle the
// slave takes the request, so a request still high afterwards is not
// accepted a second time.
interface pc_jump_sequencer_if #(
    parameter int PC_WIDTH = 8
);
    logic                jump_req;
    logic [PC_WIDTH-1:0] jump_target;
    logic                jump_ack;
`ifdef PC_RETURN_STACK_EN
    logic                jump_call;
    logic                jump_ret;

    modport master (output jump_req, output jump_target, output jump_call,
                    output jump_ret, input jump_ack);
    modport slave  (input jump_req, input jump_target, input jump_call,
                    input jump_ret, output jump_ack);
`else
    modport master (output jump_req, output jump_target, input jump_ack);
    modport slave  (input jump_req, input jump_target, output jump_ack);
`endif
endinterface

// File: rtl/pc_jump_sequencer.sv
// Program counter sequencer: advances the fetch address, takes jumps from
// the jump-decision logic with a one-cycle flush bubble, and supports
// halt/resume. state_dbg exposes the FSM state.
// Optional macro PC_RETURN_STACK_EN adds a circular return address stack
// (call pushes pc+STEP, ret pops the target) and a sticky ras_err flag.
module pc_jump_sequencer #(
    parameter int                  PC_WIDTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  STEP      = 1,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                halt,
    input  logic                resume,
    pc_jump_sequencer_if.slave  jif,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
`ifdef PC_RETURN_STACK_EN
    output logic                ras_err,
`endif
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] jump_dest;
    logic                accept;

`ifdef PC_RETURN_STACK_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    // ptr_q points at the top entry; cnt_q counts live entries (saturates,
    // so a push onto a full stack silently replaces the oldest slot).
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]       ptr_q, ptr_d, ptr_pop;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_pop;
    logic                err_q, err_d;
    logic                push;
    logic                do_ret, do_call;

    assign do_ret  = accept && jif.jump_ret;
    assign do_call = accept && jif.jump_call;

    // Return redirects to the stacked address; an empty stack falls back to RESET_PC.
    always_comb begin
        jump_dest = jif.jump_target;
        if (jif.jump_ret) begin
            jump_dest = (cnt_q != '0) ? ras_q[ptr_q] : RESET_PC;
        end
    end

    // Stack pointer update: pop first, then push, so call+ret replaces the top.
    always_comb begin
        ptr_pop = ptr_q;
        cnt_pop = cnt_q;
        err_d   = err_q;
        push    = 1'b0;
        if (do_ret) begin
            if (cnt_q != '0) begin
                ptr_pop = ptr_q - PW'(1);
                cnt_pop = cnt_q - CW'(1);
            end else begin
                err_d = 1'b1;
            end
        end
        ptr_d = ptr_pop;
        cnt_d = cnt_pop;
        if (do_call) begin
            push  = 1'b1;
            ptr_d = ptr_pop + PW'(1);
            cnt_d = (cnt_pop == CW'(RAS_DEPTH)) ? cnt_pop : cnt_pop + CW'(1);
        end
    end

    // Stack storage, pointer, count and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (push) begin
                ras_q[ptr_d] <= pc_q + STEP_W;
            end
        end
    end

    assign ras_err = err_q;
`else
    assign jump_dest = jif.jump_target;
`endif

    // Next state / next pc: in RUN, halt beats jump beats advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        accept  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (jif.jump_req) begin
                    accept  = 1'b1;
                    pc_d    = jump_dest;
                    state_d = ST_FLUSH;
                end else if (en) begin
                    pc_d = pc_q + STEP_W;
                end
            end
            ST_FLUSH: begin
                state_d = halt ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: begin
                if (resume && !halt) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // State and pc registers; reset parks in FLUSH so the first cycle is a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FLUSH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign jif.jump_ack = accept;
    assign pc           = pc_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_pc_jump_sequencer.sv
// Self-checking bench for pc_jump_sequencer. Main DUT: RESET_PC=0x10, STEP=1.
// Second DUT: RESET_PC=0xFE, STEP=3, en tied high, for the STEP wrap case.
// Define PC_RETURN_STACK_EN to also exercise the return stack.
module tb_pc_jump_sequencer;
    localparam int W = 10;

    logic       clk;
    logic       reset;
    logic       en, halt, resume;
    logic [7:0] pc;
    logic       pc_valid;
    logic [1:0] state_dbg;
    logic [7:0] pc3;
    logic       pc_valid3;
    logic [1:0] state_dbg3;
`ifdef PC_RETURN_STACK_EN
    logic       ras_err;
    logic       ras_err3;
`endif

    logic [W-1:0] exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;

    pc_jump_sequencer_if #(.PC_WIDTH(8)) jif ();
    pc_jump_sequencer_if #(.PC_WIDTH(8)) jif3 ();

    pc_jump_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h10), .STEP(1), .RAS_DEPTH(4)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .halt      (halt),
        .resume    (resume),
        .jif       (jif),
        .pc        (pc),
        .pc_valid  (pc_valid),
`ifdef PC_RETURN_STACK_EN
        .ras_err   (ras_err),
`endif
        .state_dbg (state_dbg)
    );

    pc_jump_sequencer #(.PC_WIDTH(8), .RESET_PC(8'hFE), .STEP(3), .RAS_DEPTH(4)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .en        (1'b1),
        .halt      (1'b0),
        .resume    (1'b0),
        .jif       (jif3),
        .pc        (pc3),
        .pc_valid  (pc_valid3),
`ifdef PC_RETURN_STACK_EN
        .ras_err   (ras_err3),
`endif
        .state_dbg (state_dbg3)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, queue the expected
    // {jump_ack, pc_valid, pc} for this cycle, then sample and compare.
    task automatic cyc(input string tag, input logic e, input logic rq, input logic [7:0] tg,
                       input logic h, input logic rs,
                       input logic [7:0] epc, input logic ev, input logic ea);
        logic [W-1:0] got;
        @(negedge clk);
        en              = e;
        jif.jump_req    = rq;
        jif.jump_target = tg;
        halt            = h;
        resume          = rs;
        exp_q.push_back({ea, ev, epc});
        #1;
        got = {jif.jump_ack, pc_valid, pc};
        check(tag, 16'(got), 16'(exp_q.pop_front()));
    endtask

    initial begin
        logic [7:0] p;
        logic       e;
        logic [W-1:0] got;
        reset = 1'b1;
        en = 1'b0; halt = 1'b0; resume = 1'b0;
        jif.jump_req = 1'b0; jif.jump_target = '0;
        jif3.jump_req = 1'b0; jif3.jump_target = '0;
`ifdef PC_RETURN_STACK_EN
        jif.jump_call = 1'b0; jif.jump_ret = 1'b0;
        jif3.jump_call = 1'b0; jif3.jump_ret = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset state: pending request is not acked
        cyc("reset", 1, 1, 8'h99, 0, 0, 8'h10, 0, 0);
        check("reset_s3", 16'({pc_valid3, pc3}), 16'({1'b0, 8'hFE}));
        reset = 1'b0;

        // Boot: bubble already seen, then 10, 11, 12
        cyc("boot0", 1, 0, 8'h00, 0, 0, 8'h10, 1, 0);
        check("boot0_s3", 16'({pc_valid3, pc3}), 16'({1'b1, 8'hFE}));
        cyc("boot1", 1, 0, 8'h00, 0, 0, 8'h11, 1, 0);
        check("wrap_s3", 16'({pc_valid3, pc3}), 16'({1'b1, 8'h01}));
        cyc("boot2", 1, 0, 8'h00, 0, 0, 8'h12, 1, 0);

        // Jump to 05, then 40 with the request held two cycles
        cyc("j05",   0, 1, 8'h05, 0, 0, 8'h13, 1, 1);
        cyc("j05f",  1, 0, 8'h00, 0, 0, 8'h05, 0, 0);
        cyc("j40a",  0, 1, 8'h40, 0, 0, 8'h05, 1, 1);
        cyc("j40b",  1, 1, 8'h40, 0, 0, 8'h40, 0, 0);
        cyc("j40c",  1, 0, 8'h00, 0, 0, 8'h40, 1, 0);
        cyc("j40d",  0, 0, 8'h00, 0, 0, 8'h41, 1, 0);

        // Wrap FF -> 00
        cyc("jff",   0, 1, 8'hFF, 0, 0, 8'h41, 1, 1);
        cyc("jfff",  0, 0, 8'h00, 0, 0, 8'hFF, 0, 0);
        cyc("wrap",  1, 0, 8'h00, 0, 0, 8'hFF, 1, 0);
        cyc("wrap1", 0, 0, 8'h00, 0, 0, 8'h00, 1, 0);

        // Halt beats jump; halt beats resume; resume alone returns to RUN
        cyc("hjmp",  1, 1, 8'h77, 1, 0, 8'h00, 1, 0);
        cyc("hres",  1, 1, 8'h77, 1, 1, 8'h00, 0, 0);
        cyc("res",   1, 1, 8'h77, 0, 1, 8'h00, 0, 0);
        cyc("run",   0, 0, 8'h00, 0, 0, 8'h00, 1, 0);

        // Halt during the flush bubble
        cyc("j20",   0, 1, 8'h20, 0, 0, 8'h00, 1, 1);
        cyc("fhalt", 1, 1, 8'h20, 1, 0, 8'h20, 0, 0);
        cyc("hres2", 0, 0, 8'h00, 0, 1, 8'h20, 0, 0);
        cyc("r20",   0, 0, 8'h00, 0, 0, 8'h20, 1, 0);

        // Random advance pattern
        p = 8'h20;
        for (int i = 0; i < 24; i++) begin
            e = 1'($urandom_range(0, 1));
            cyc("rnd", e, 0, 8'h00, 0, 0, p, 1, 0);
            p = p + 8'(e);
        end

        // Async reset in the flush bubble after a jump to 40
        cyc("j40r",  0, 1, 8'h40, 0, 0, p, 1, 1);
        @(negedge clk);
        en = 1'b1; jif.jump_req = 1'b1; jif.jump_target = 8'h40;
        exp_q.push_back({1'b0, 1'b0, 8'h40});
        #1;
        got = {jif.jump_ack, pc_valid, pc};
        check("flush40", 16'(got), 16'(exp_q.pop_front()));
        reset = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 8'h10});
        #1;
        got = {jif.jump_ack, pc_valid, pc};
        check("async_rst", 16'(got), 16'(exp_q.pop_front()));
        cyc("rst_hold", 1, 1, 8'h40, 0, 0, 8'h10, 0, 0);
        reset = 1'b0;
        cyc("rel",   1, 0, 8'h00, 0, 0, 8'h10, 1, 0);

`ifdef PC_RETURN_STACK_EN
        // Call 08 -> 30, return to 09
        cyc("j08",   0, 1, 8'h08, 0, 0, 8'h11, 1, 1);
        cyc("j08f",  0, 0, 8'h00, 0, 0, 8'h08, 0, 0);
        check("ras_err0", 16'(ras_err), 16'h0);
        jif.jump_call = 1'b1;
        cyc("call30", 0, 1, 8'h30, 0, 0, 8'h08, 1, 1);
        jif.jump_call = 1'b0;
        cyc("call30f", 0, 0, 8'h00, 0, 0, 8'h30, 0, 0);
        jif.jump_ret = 1'b1;
        cyc("ret09", 0, 1, 8'hAA, 0, 0, 8'h30, 1, 1);
        jif.jump_ret = 1'b0;
        cyc("ret09f", 0, 0, 8'h00, 0, 0, 8'h09, 0, 0);
        check("ras_err1", 16'(ras_err), 16'h0);

        // Return on an empty stack
        jif.jump_ret = 1'b1;
        cyc("retE",  0, 1, 8'hAA, 0, 0, 8'h09, 1, 1);
        jif.jump_ret = 1'b0;
        cyc("retEf", 0, 0, 8'h00, 0, 0, 8'h10, 0, 0);
        check("ras_err2", 16'(ras_err), 16'h1);

        // Five calls into a 4-deep stack, then four returns
        p = 8'h10;
        for (int k = 0; k < 5; k++) begin
            jif.jump_call = 1'b1;
            cyc("callN", 0, 1, 8'(8'h60 + 8'(k) * 8'h10), 0, 0, p, 1, 1);
            jif.jump_call = 1'b0;
            p = 8'(8'h60 + 8'(k) * 8'h10);
            cyc("callNf", 0, 0, 8'h00, 0, 0, p, 0, 0);
        end
        for (int k = 0; k < 4; k++) begin
            jif.jump_ret = 1'b1;
            cyc("retN", 0, 1, 8'h00, 0, 0, p, 1, 1);
            jif.jump_ret = 1'b0;
            p = 8'(8'h91 - 8'(k) * 8'h10);
            cyc("retNf", 0, 0, 8'h00, 0, 0, p, 0, 0);
        end
        check("ras_err3", 16'(ras_err), 16'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pc_jump_sequencer.md
Name: pc_jump_sequencer

Overview:
- Program counter sequencer; the consumer end of the jump-decision path.
- Takes jump requests and targets from the jump-condition logic over a req/ack handshake.
- Produces the fetch address `pc`, handles the one-cycle flush bubble after a taken jump, and supports halt/resume.
- Sits between the jump-decision logic and instruction memory addressing.

Parameters:
- PC_WIDTH, 8, width of pc and jump_target
- RESET_PC, 0, pc value loaded on reset
- STEP, 1, pc increment per advance (modulo 2^PC_WIDTH)
- RAS_DEPTH, 4, return stack entries (used only with the optional feature; power of 2)

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- en  input  1  advance pc by STEP this cycle
- jump_req  input  1  level request; held until jump_ack seen
- jump_target  input  PC_WIDTH  target address, valid while jump_req=1
- jump_ack  output  1  combinational; high in the cycle the request is accepted
- halt  input  1  stop fetching
- resume  input  1  leave HALTED
- pc  output  PC_WIDTH  current fetch address (registered)
- pc_valid  output  1  pc is a valid fetch address this cycle (= state==RUN)

Behaviour:
- Reset (async, active-high):
  - pc=RESET_PC, state=FLUSH, so pc_valid=0 and jump_ack=0.
  - The first cycle after release is a bubble; RUN follows next.
- States:
  - RUN: pc_valid=1.
  - FLUSH: one-cycle bubble, pc_valid=0.
  - HALTED: pc_valid=0.
- RUN priority, sampled each posedge:
  1. halt=1: go to HALTED, pc holds. jump_ack=0 even if jump_req=1.
  2. jump_req=1: jump_ack=1 this cycle, pc<=jump_target, go to FLUSH.
  3. en=1: pc<=pc+STEP, truncated to PC_WIDTH (wraps 2^PC_WIDTH-1 -> 0 with STEP=1).
  4. Otherwise: hold.
- FLUSH:
  - Lasts exactly one cycle; pc holds.
  - jump_req is ignored (jump_ack=0) and en is ignored.
  - Next state: HALTED if halt=1, else RUN.
- HALTED:
  - pc holds; en and jump_req are ignored, jump_ack=0.
  - resume=1 and halt=0: go to RUN.
  - halt=1 and resume=1: stay HALTED (halt wins).
- Jump latency:
  - Accepted at edge N: pc=jump_target from N+1, with pc_valid=0 for cycle N+1.
  - From N+2: pc_valid=1 and pc=jump_target; increments resume on later en.
- Handshake:
  - The requester must hold jump_req and jump_target stable until it samples jump_ack=1, then may deassert.
  - If jump_req is still high in the cycle after ack, the state is FLUSH, so it is ignored and not double-accepted.
  - Back-to-back jumps are therefore separated by at least one bubble.
- Reset mid-operation: immediate return to reset values regardless of state or a pending request; no ack is issued.

Optional Feature:
- Macro: PC_RETURN_STACK_EN.
- With the macro defined:
  - Adds inputs jump_call (1) and jump_ret (1), qualified by jump_req, and output ras_err (1, sticky, reset 0).
  - Adds a RAS_DEPTH-entry return address stack; the pointer resets to empty.
  - Accepted jump with jump_call=1: push pc+STEP.
  - Full stack on push: overwrite the oldest entry (circular); no error.
  - Accepted jump with jump_ret=1: target = popped top; jump_target is ignored.
  - Pop from an empty stack: target=RESET_PC, ras_err<=1.
  - jump_call and jump_ret both 1: ret takes precedence; pop then push, so the top is replaced by pc+STEP.
- Without the macro: no extra ports or storage; behaviour exactly as above.

Test Plan:
- Reset with RESET_PC=0x10, release, en=1 constantly -> pc_valid 0 for 1 cycle, then pc=0x10, 0x11, 0x12 with pc_valid=1.
- pc=0x05, jump_req=1 with target 0x40 held 2 cycles -> jump_ack high exactly 1 cycle; next cycle pc=0x40 pc_valid=0; then pc=0x40 valid, then 0x41; only one acceptance.
- pc=0xFF, en=1, STEP=1 -> pc=0x00; STEP=3 from 0xFE -> 0x01.
- halt and jump_req asserted together in RUN -> HALTED, jump_ack=0, pc held; halt=1 with resume=1 -> stay halted; resume alone -> RUN, pc unchanged, pc_valid=1.
- Assert reset during FLUSH after a jump to 0x40 -> pc=RESET_PC immediately (async), pc_valid=0, no jump_ack.
- With PC_RETURN_STACK_EN:
  - call from 0x08 to 0x30, then ret -> pc=0x09.
  - ret on an empty stack -> pc=RESET_PC and ras_err=1 (sticky).
  - Five calls with RAS_DEPTH=4, then four rets -> pops return the last four pushes in reverse order.
